regfile: RTL
============

# regfile

Architectural register file for the single-cycle processor: 32 registers of 32 bits, two combinational read ports and one synchronous write port. It sits directly downstream of the write-select decode: `ctrl_writeReg` is expanded to a one-hot per-register write enable. That enable gates the register bank, whose outputs feed the ALU operand muxes. Register 0 reads as zero at all times, and writes to it are discarded.

## Interface
- `WIDTH`, 32, data width of each register and of all data ports.
- `BYPASS`, 1, when 1, a read of the register being written in the same cycle returns the write data; when 0, it returns the stored value.
- `clock` in 1 — sole clock; all state updates on the rising edge.
- `reset_n` in 1 — synchronous, active-low reset; sampled on the rising edge of `clock`.
- `ctrl_writeEnable` in 1 — write request for the current cycle.
- `ctrl_writeReg` in 5 — destination register index.
- `data_writeReg` in WIDTH — write data.
- `ctrl_readRegA` in 5 — port A read index.
- `ctrl_readRegB` in 5 — port B read index.
- `data_readRegA` out WIDTH — port A read data, combinational.
- `data_readRegB` out WIDTH — port B read data, combinational.

## Operation
- **Storage:** registers r1..r31 are WIDTH-bit flops. r0 has no storage and is a constant 0.
- **Write decode:** `ctrl_writeReg` drives a 5-to-32 decoder whose enable is `ctrl_writeEnable & reset_n`. Output bit k is the write strobe for rk. Bit 0 is ignored.
- **Write:**
  - At the rising edge, if `reset_n`=1, `ctrl_writeEnable`=1 and `ctrl_writeReg`≠0, then r[`ctrl_writeReg`] ← `data_writeReg`.
  - Exactly one register changes per edge at most.
- **Reset:**
  - At a rising edge with `reset_n`=0, r1..r31 ← 0.
  - Any write requested in that cycle is discarded; reset wins over a simultaneous write.
  - Reset asserted for any number of cycles keeps all registers 0.
- **Read, general case:** `data_readRegX` = r[`ctrl_readRegX`]. Index 0 always returns 0.
- **Read with BYPASS=1:** if `reset_n`=1, `ctrl_writeEnable`=1, `ctrl_writeReg`≠0 and `ctrl_readRegX`==`ctrl_writeReg`, then `data_readRegX` = `data_writeReg` combinationally.
- **Read with BYPASS=0:** the same case returns the old value until the edge.
- **Bypass suppression:** the bypass is suppressed while `reset_n`=0.
- **Port independence:** both ports may address the same register, including r0. Both return identical data.
- **Width rule:** no extension or truncation. All data paths are exactly WIDTH bits.

## Timing
- **Write latency:** data presented in cycle n is visible on a non-bypassed read from cycle n+1, after edge n.
- **Read latency:** 0 cycles from address to data. The path is purely combinational through a 32:1 mux per port.
- **Reset values:**
  - After the first rising edge with `reset_n`=0, both read outputs are 0 for every index.
  - Before any reset edge, register contents are undefined, except r0 = 0.
- **Reset mid-operation:** a write held across the reset-deasserting edge takes effect at that edge only if `reset_n`=1 when sampled. The cycle that sampled `reset_n`=0 leaves all registers 0.
- **Simultaneous events:**
  - A write and two reads of the same register in one cycle is legal.
  - A write to r0 with a read of r0 returns 0 regardless of BYPASS.

## Structure
- Shared package: `REG_COUNT`=32, `REG_IDX_W`=5, `REG_ZERO`=5'd0, and the default data width constant used by the datapath.
- **Sub-module:** `decoder_5_to_32`, the existing block, is instantiated once for write-strobe generation. Its `en` is driven by `ctrl_writeEnable & reset_n`.
- **Storage:** the register bank is generated as 31 WIDTH-bit flop groups, each with synchronous clear and strobe-gated load.
- **Read muxes:** two read muxes plus the bypass compare live in this module.

## Test plan
- **Reset clear:** hold `reset_n`=0 for 2 cycles with `ctrl_writeEnable`=1, `ctrl_writeReg`=5, data 0xDEADBEEF. Then read A=5, B=31 → both 0.
- **Basic write/read:** write r7←0x12345678 at cycle n. At n+1 read A=7 → 0x12345678 and B=8 → 0.
- **r0 immutability:** write r0←0xFFFFFFFF, then read A=0, B=0 → both 0, same cycle and next cycle, for BYPASS=0 and 1.
- **Bypass:** r3 holds 0x11111111. In the same cycle, write r3←0x22222222 with read A=3.
  - BYPASS=1 → A=0x22222222.
  - BYPASS=0 → A=0x11111111, then 0x22222222 next cycle.
- **Full sweep:** write rk←k×0x01010101 for k=1..31, then read all pairs (k, 32−k) → expected values on both ports.
- **Reset mid-operation:** r9=0xCAFEF00D. Assert `reset_n`=0 for one cycle with write r9←0xA5A5A5A5 → r9=0. Deassert with the same write → r9=0xA5A5A5A5 one cycle later.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants for the architectural register file and its write decode.
package regfile_pkg;

    localparam int REG_COUNT = 32;
    localparam int REG_IDX_W = 5;
    localparam int DATA_W    = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_decoder.sv
// 5-to-32 one-hot decoder producing the per-register write strobes.
module decoder_5_to_32
    import regfile_pkg::*;
(
    input  logic                 en,
    input  logic [REG_IDX_W-1:0] idx,
    output logic [REG_COUNT-1:0] onehot
);

    // Raise exactly one strobe bit when enabled, none otherwise.
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile.sv
// 32 x WIDTH register file: two combinational read ports, one synchronous
// write port, r0 hard-wired to zero, optional same-cycle write-to-read bypass.
module regfile
    import regfile_pkg::*;
#(
    parameter int WIDTH  = DATA_W,
    parameter bit BYPASS = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 ctrl_writeEnable,
    input  logic [REG_IDX_W-1:0] ctrl_writeReg,
    input  logic [WIDTH-1:0]     data_writeReg,
    input  logic [REG_IDX_W-1:0] ctrl_readRegA,
    input  logic [REG_IDX_W-1:0] ctrl_readRegB,
    output logic [WIDTH-1:0]     data_readRegA,
    output logic [WIDTH-1:0]     data_readRegB
);

    // Strobes already carry reset_n, so a held-low reset blocks both the
    // load and the bypass through the same signal.
    logic [REG_COUNT-1:0]            write_strobe;
    logic [REG_COUNT-1:0][WIDTH-1:0] read_view;
    logic                            bypass_a;
    logic                            bypass_b;

    decoder_5_to_32 u_write_decode (
        .en     (ctrl_writeEnable & reset_n),
        .idx    (ctrl_writeReg),
        .onehot (write_strobe)
    );

    generate
        for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                // r0 has no storage; it always reads as zero.
                assign read_view[gi] = '0;
            end else begin : g_store
                logic [WIDTH-1:0] value_reg;

                // Synchronous clear wins over a strobe-gated load.
                always_ff @(posedge clock) begin
                    if (!reset_n) begin
                        value_reg <= '0;
                    end else if (write_strobe[gi]) begin
                        value_reg <= data_writeReg;
                    end
                end

                assign read_view[gi] = value_reg;
            end
        end
    endgenerate

    // Read muxes; a live write to the addressed non-zero register forwards
    // the write data when bypass is enabled.
    always_comb begin
        bypass_a = BYPASS && write_strobe[ctrl_readRegA] && (ctrl_readRegA != REG_ZERO);
        bypass_b = BYPASS && write_strobe[ctrl_readRegB] && (ctrl_readRegB != REG_ZERO);
        data_readRegA = bypass_a ? data_writeReg : read_view[ctrl_readRegA];
        data_readRegB = bypass_b ? data_writeReg : read_view[ctrl_readRegB];
    end

endmodule
